// File: rtl/blockram_banked.sv
// Single-clock banked block RAM: 4 KiB banks, per-byte write enables, optional output
// register, selectable write-first/read-first collision result and a zero-fill engine.
module blockram_banked #(
    parameter int WIDTH   = 0,
    parameter int DEPTH   = 1,
    parameter int OUT_REG = 0,
    parameter int BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [12+DEPTH-1:0]   rd_addr,
    output logic [(8<<WIDTH)-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [12+DEPTH-1:0]   wr_addr,
    input  logic [(8<<WIDTH)-1:0] wr_data,
    input  logic [(1<<WIDTH)-1:0] wr_be,
    input  logic                  clear,
    output logic                  busy
);
    localparam int DW  = 8 << WIDTH;
    localparam int BE  = 1 << WIDTH;
    localparam int LAW = 12 - WIDTH;
    localparam int NB  = 1 << (WIDTH + DEPTH);
    localparam int WPB = 4096 >> WIDTH;
    localparam int BSW = (WIDTH + DEPTH > 0) ? WIDTH + DEPTH : 1;

    if (WIDTH < 0 || WIDTH > 3) begin : g_bad_width
        $error("blockram_banked: WIDTH must be in 0..3");
    end

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic [LAW-1:0]   cnt;
    logic             rd_acc, wr_acc;
    logic [BSW-1:0]   rd_bank, wr_bank, sel_q;
    logic [LAW-1:0]   rd_local, wr_local;
    logic             rd_v1, hit_q;
    logic [DW-1:0]    wdata_q, merged;
    logic [BE-1:0]    wbe_q;
    logic [DW-1:0]    bank_out [NB];

    assign rd_acc   = rd_en && !busy;
    assign wr_acc   = wr_en && !busy;
    assign rd_bank  = BSW'(rd_addr >> LAW);
    assign wr_bank  = BSW'(wr_addr >> LAW);
    assign rd_local = rd_addr[LAW-1:0];
    assign wr_local = wr_addr[LAW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (clear) begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
                CLEAR: begin
                    if (cnt == LAW'(WPB - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DW-1:0] mem [WPB];
        logic [DW-1:0] q;

        // NOTE: memory arrays and their read registers take no reset, so they map onto block RAM.
        always_ff @(posedge clk) begin
            if (busy) begin
                mem[cnt] <= '0;
            end else if (wr_acc && wr_bank == BSW'(b)) begin
                for (int k = 0; k < BE; k++) begin
                    if (wr_be[k]) mem[wr_local][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
            if (rd_acc) q <= mem[rd_local];
        end

        assign bank_out[b] = q;
    end

    // Collision result is rebuilt from registered write data, independent of the RAM's own mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1   <= 1'b0;
            sel_q   <= '0;
            hit_q   <= 1'b0;
            wdata_q <= '0;
            wbe_q   <= '0;
        end else begin
            rd_v1 <= rd_acc;
            if (rd_acc) begin
                sel_q   <= rd_bank;
                hit_q   <= (BYPASS != 0) && wr_acc && (wr_addr == rd_addr);
                wdata_q <= wr_data;
                wbe_q   <= wr_be;
            end
        end
    end

    // NOTE: assigning merged in full before the lane loop keeps this block free of latches.
    always_comb begin
        merged = bank_out[sel_q];
        for (int k = 0; k < BE; k++) begin
            if (hit_q && wbe_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] out_q;
        logic          v2;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
                v2    <= 1'b0;
            end else begin
                v2 <= rd_v1;
                if (rd_v1) out_q <= merged;
            end
        end

        assign rd_data  = out_q;
        assign rd_valid = v2;
    end else begin : g_out_direct
        logic [DW-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (rst)        hold_q <= '0;
            else if (rd_v1) hold_q <= merged;
        end

        assign rd_data  = rd_v1 ? merged : hold_q;
        assign rd_valid = rd_v1;
    end
endmodule

// File: tb/tb_blockram_banked.sv
// Bench for blockram_banked: two 32-bit instances (write-first/latency 1 and read-first/latency 2)
// on shared stimulus, compared every cycle against a word-array reference model.
module tb_blockram_banked;
    localparam int WIDTH  = 2;
    localparam int DEPTH  = 1;
    localparam int AW     = 12 + DEPTH;
    localparam int DW     = 8 << WIDTH;
    localparam int BE     = 1 << WIDTH;
    localparam int WPB    = 4096 >> WIDTH;
    localparam int NWORDS = 1 << AW;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, rd_en, wr_en, clear;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [BE-1:0] wr_be;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b, busy_a, busy_b;

    logic [DW-1:0] ref_mem [NWORDS];
    exp_t          qa[$], qb[$];
    logic [DW-1:0] last_a, last_b;
    bit            model_busy;
    int            busy_left;
    int            cyc;
    int            n_checks, n_fail;

    always #5 clk = ~clk;

    blockram_banked #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clear(clear), .busy(busy_a)
    );

    blockram_banked #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clear(clear), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [BE-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < BE; k++) if (be[k]) r[8*k +: 8] = data[8*k +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return AW'(0);
            1:       return AW'(WPB - 1);
            2:       return AW'(WPB);
            3:       return AW'(NWORDS - 1);
            default: return AW'($urandom_range(0, NWORDS - 1));
        endcase
    endfunction

    // One clock: model the edge from the current inputs, then check both instances.
    task automatic cycle();
        bit            acc_rd, acc_wr, va, vb;
        logic [DW-1:0] old;
        acc_rd = rd_en && !model_busy && !rst;
        acc_wr = wr_en && !model_busy && !rst;
        if (acc_rd) begin
            old = ref_mem[rd_addr];
            qa.push_back('{cyc + 1, (acc_wr && wr_addr == rd_addr) ? merge(old, wr_data, wr_be) : old});
            qb.push_back('{cyc + 2, old});
        end
        if (acc_wr) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
        if (rst) begin
            model_busy = 1'b0;
            busy_left  = 0;
        end else if (model_busy) begin
            busy_left--;
            if (busy_left == 0) model_busy = 1'b0;
        end else if (clear) begin
            model_busy = 1'b1;
            busy_left  = WPB;
            for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
        end
        #1;
        va = qa.size() > 0 && qa[0].due == cyc;
        if (va) begin
            last_a = qa[0].data;
            void'(qa.pop_front());
        end
        vb = qb.size() > 0 && qb[0].due == cyc;
        if (vb) begin
            last_b = qb[0].data;
            void'(qb.pop_front());
        end
        check("rd_valid_a", DW'(rd_valid_a), DW'(va));
        check("rd_data_a", rd_data_a, last_a);
        check("rd_valid_b", DW'(rd_valid_b), DW'(vb));
        check("rd_data_b", rd_data_b, last_b);
        check("busy_a", DW'(busy_a), DW'(model_busy));
        check("busy_b", DW'(busy_b), DW'(model_busy));
    endtask

    task automatic idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
        clear = 1'b0;
    endtask

    // Start a clear with a same-cycle read and write, hammer requests while busy, count busy cycles.
    task automatic run_clear(input int abort_at);
        int n;
        rd_en = 1'b1; rd_addr = pick_addr();
        wr_en = 1'b1; wr_addr = rd_addr + AW'(1); wr_data = $urandom(); wr_be = '1;
        clear = 1'b1;
        cycle();
        n = 0;
        while (busy_a === 1'b1 && n < 3000 && n != abort_at) begin
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = pick_addr();
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = pick_addr();
            wr_data = $urandom();
            wr_be   = BE'($urandom_range(0, (1 << BE) - 1));
            clear   = (n == 50);
            cycle();
            n++;
        end
        idle();
        if (abort_at < 0) check("busy_cycles", DW'(n), DW'(WPB));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        model_busy = 1'b0; busy_left = 0;
        last_a = '0; last_b = '0;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = 'x;
        rst = 1'b1; idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("reset_rd_data_b", rd_data_b, '0);

        // Initial zero-fill so every word is defined.
        run_clear(-1);
        cycle();

        // Partial byte-lane overwrite.
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'h1122_3344; wr_be = 4'b1111;
        cycle();
        wr_data = 32'hAABB_CCDD; wr_be = 4'b0101;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = AW'(5);
        cycle();
        rd_en = 1'b0;
        check("be_merge_a", rd_data_a, 32'h11BB_33DD);
        cycle();
        check("be_merge_b", rd_data_b, 32'h11BB_33DD);

        // Same-cycle read/write collision, then read-after-write.
        wr_en = 1'b1; wr_addr = AW'(7); wr_data = '0; wr_be = '1;
        cycle();
        wr_data = 32'hFFFF_FFFF; wr_be = 4'b1100; rd_en = 1'b1; rd_addr = AW'(7);
        cycle();
        check("collide_bypass", rd_data_a, 32'hFFFF_0000);
        wr_en = 1'b0;
        cycle();
        rd_en = 1'b0;
        check("collide_readfirst", rd_data_b, 32'h0000_0000);
        check("raw_next_a", rd_data_a, 32'hFFFF_0000);
        cycle();
        check("raw_next_b", rd_data_b, 32'hFFFF_0000);

        // Streaming reads across the bank 0/1 boundary.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = AW'(WPB - 8 + i); wr_data = $urandom(); wr_be = '1;
            cycle();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = AW'(WPB - 8 + i);
            cycle();
        end
        idle(); cycle(); cycle();

        // Random traffic with frequent collisions and bank-edge addresses.
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = pick_addr();
            wr_data = $urandom();
            wr_be   = BE'($urandom_range(0, (1 << BE) - 1));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = $urandom_range(0, 1) ? wr_addr : pick_addr();
            cycle();
        end
        idle(); cycle(); cycle();

        // Fill a pattern, clear, then read every word back.
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i * 255); wr_data = 32'hC0DE_0000 | i; wr_be = '1;
            cycle();
        end
        idle();
        run_clear(-1);
        for (int i = 0; i < NWORDS; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            cycle();
        end
        idle(); cycle(); cycle();

        // Reset in the middle of a clear.
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'hDEAD_BEEF; wr_be = '1;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = AW'(3);
        cycle();
        idle(); cycle(); cycle();
        run_clear(100);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_busy", DW'(busy_a), '0);
        check("abort_rd_valid", DW'(rd_valid_b), '0);
        check("abort_rd_data", rd_data_b, '0);
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'h1234_5678; wr_be = '1;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = AW'(3);
        cycle();
        idle();
        check("post_reset_rd_a", rd_data_a, 32'h1234_5678);
        cycle();
        check("post_reset_rd_b", rd_data_b, 32'h1234_5678);
        run_clear(-1);
        for (int i = 0; i < 64; i++) begin
            rd_en = 1'b1; rd_addr = (i == 0) ? AW'(3) : pick_addr();
            cycle();
        end
        idle(); cycle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
